// File: rtl/stage_fetch_buffered_pkg.sv
// Shared definitions for the buffered instruction-fetch stage.
//   HALT_OPCODE   : instruction word that stops fetch when halt detection is built in
//   PC_INC        : byte increment between consecutive instruction words
//   fetch_state_e : fetch FSM states (RUN, HALTED)
package stage_fetch_buffered_pkg;

    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
    localparam int unsigned PC_INC      = 4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/stage_fetch_buffered_imem.sv
// fetch_imem: word-addressed instruction memory, DEPTH x DATA_W.
// One synchronous write port (program load) and one synchronous read port.
// Read-first: a read and write to the same word on one edge returns old data.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_raddr  : read word index (sampled every cycle)
//   o_rdata  : read data, valid one cycle after i_raddr is presented
module fetch_imem #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 256,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = mem[i_raddr];
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/stage_fetch_buffered.sv
// stage_fetch_buffered: IF stage with PC register, synchronous instruction
// memory and a FETCH_DEPTH-entry prefetch FIFO in front of decode.
// Optional feature macro: FETCH_HALT_DETECT_EN (stop fetch after HALT word is consumed).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_taken           : redirect from MEM (flushes FIFO and in-flight read)
//   i_branch_address  : redirect target
//   i_PC_write        : 1 = decode consumes head word, 0 = hold outputs
//   i_imem_we/waddr/wdata : program-load write port
//   o_valid, o_instruction, o_pc : head word, its PC + 4
//   o_halted          : fetch stopped on HALT word
module stage_fetch_buffered
    import stage_fetch_buffered_pkg::*;
#(
    parameter  int unsigned       DATA_W      = 32,
    parameter  int unsigned       ADDR_W      = 32,
    parameter  int unsigned       IMEM_DEPTH  = 256,
    parameter  int unsigned       FETCH_DEPTH = 4,
    parameter  logic [ADDR_W-1:0] RESET_PC    = '0,
    localparam int unsigned       IMEM_AW     = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_taken,
    input  logic [ADDR_W-1:0]  i_branch_address,
    input  logic               i_PC_write,
    input  logic               i_imem_we,
    input  logic [IMEM_AW-1:0] i_imem_waddr,
    input  logic [DATA_W-1:0]  i_imem_wdata,
    output logic               o_valid,
    output logic [DATA_W-1:0]  o_instruction,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_halted
);

    localparam int unsigned PTR_W = $clog2(FETCH_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    fetch_state_e      state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fifo_instr_q [FETCH_DEPTH];
    logic [DATA_W-1:0] fifo_instr_d [FETCH_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q    [FETCH_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d    [FETCH_DEPTH];

    logic [DATA_W-1:0] imem_rdata;
    logic [CNT_W:0]    occupancy;
    logic              head_valid, pop, push, issue, halt_pop;

    // Memory is read at the PC every cycle; the result is only kept when
    // inflight_q marks it as a live (non-flushed) issue.
    fetch_imem #(
        .DATA_W (DATA_W),
        .DEPTH  (IMEM_DEPTH)
    ) u_imem (
        .clk     (clk),
        .i_we    (i_imem_we),
        .i_waddr (i_imem_waddr),
        .i_wdata (i_imem_wdata),
        .i_raddr (pc_q[IMEM_AW+1:2]),
        .o_rdata (imem_rdata)
    );

    always_comb begin
        pc_d          = pc_q;
        state_d       = state_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;

        head_valid = (count_q != '0) && (state_q == ST_RUN);
        pop        = head_valid && i_PC_write;
        push       = inflight_q;
        // Credit: buffered words plus the read in flight never exceed the FIFO size,
        // so a returning word always has a slot.
        occupancy  = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q);
        issue      = (state_q == ST_RUN) && (occupancy < (CNT_W+1)'(FETCH_DEPTH));

        halt_pop = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
        halt_pop = pop && (fifo_instr_q[rd_ptr_q] == DATA_W'(HALT_OPCODE));
`endif

        if (issue) begin
            pc_d          = pc_q + ADDR_W'(PC_INC);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
        if (push) begin
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
            wr_ptr_d               = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (halt_pop) begin
            state_d    = ST_HALTED;
            pc_d       = pc_q;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end

        // Redirect overrides everything above; no read is issued on this edge
        // so nothing from the old path can be pushed afterwards.
        if (i_taken) begin
            state_d    = ST_RUN;
            pc_d       = i_branch_address;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end

        o_valid       = head_valid;
        o_instruction = head_valid ? fifo_instr_q[rd_ptr_q] : '0;
        o_pc          = head_valid ? fifo_pc_q[rd_ptr_q] + ADDR_W'(PC_INC) : '0;
`ifdef FETCH_HALT_DETECT_EN
        o_halted      = (state_q == ST_HALTED);
`else
        o_halted      = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            state_q       <= ST_RUN;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            state_q       <= state_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: outputs are gated by count_q.
    always_ff @(posedge clk) begin
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end

endmodule
